universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg.sv | 73 +++++++
 tb/tb_universal_shift_reg.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// Optional registered serial output is enabled by defining
// UNIVERSAL_SHIFT_REG_SEROUT_EN; without it, SHIFTOUT and its logic are absent.
module universal_shift_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] DATAIN,
`ifdef UNIVERSAL_SHIFT_REG_SEROUT_EN
    output logic             SHIFTOUT,
`endif
    output logic [WIDTH-1:0] DATAOUT
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    mode_e            mode_sel;
    logic [WIDTH-1:0] next_data;

    assign mode_sel = mode_e'(MODE);

    // Next register value; serial-in comes from DATAIN MSB (right) or LSB (left).
    always_comb begin
        next_data = DATAOUT;
        case (mode_sel)
            MODE_HOLD:  next_data = DATAOUT;
            MODE_RIGHT: next_data = {DATAIN[WIDTH-1], DATAOUT[WIDTH-1:1]};
            MODE_LEFT:  next_data = {DATAOUT[WIDTH-2:0], DATAIN[0]};
            MODE_LOAD:  next_data = DATAIN;
            default:    next_data = DATAOUT;
        endcase
    end

    // Data register; asynchronous reset clears it without a clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            DATAOUT <= '0;
        end else begin
            DATAOUT <= next_data;
        end
    end

`ifdef UNIVERSAL_SHIFT_REG_SEROUT_EN
    logic next_shift;

    // Bit pushed out by a shift; held on hold and parallel load.
    always_comb begin
        next_shift = SHIFTOUT;
        case (mode_sel)
            MODE_RIGHT: next_shift = DATAOUT[0];
            MODE_LEFT:  next_shift = DATAOUT[WIDTH-1];
            default:    next_shift = SHIFTOUT;
        endcase
    end

    // Serial-out register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            SHIFTOUT <= 1'b0;
        end else begin
            SHIFTOUT <= next_shift;
        end
    end
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg at WIDTH 4 and WIDTH 8.
// Define UNIVERSAL_SHIFT_REG_SEROUT_EN to also check SHIFTOUT.
module tb_universal_shift_reg;

    logic       clock = 1'b0;
    logic       run   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode4 = 2'b00;
    logic [3:0] din4  = 4'h0;
    logic [3:0] dout4;
    logic [1:0] mode8 = 2'b00;
    logic [7:0] din8  = 8'h00;
    logic [7:0] dout8;
`ifdef UNIVERSAL_SHIFT_REG_SEROUT_EN
    logic       sout4;
    logic       sout8;
`endif

    int vectors    = 0;
    int miscompares = 0;

    universal_shift_reg #(.WIDTH(4)) dut4 (
        .clock   (clock),
        .reset   (reset),
        .MODE    (mode4),
        .DATAIN  (din4),
`ifdef UNIVERSAL_SHIFT_REG_SEROUT_EN
        .SHIFTOUT(sout4),
`endif
        .DATAOUT (dout4)
    );

    universal_shift_reg #(.WIDTH(8)) dut8 (
        .clock   (clock),
        .reset   (reset),
        .MODE    (mode8),
        .DATAIN  (din8),
`ifdef UNIVERSAL_SHIFT_REG_SEROUT_EN
        .SHIFTOUT(sout8),
`endif
        .DATAOUT (dout8)
    );

    // Gated clock so reset can be checked with the clock stopped.
    always begin
        #5;
        if (run) clock = ~clock;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic edge_step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset with clock stopped
        #1 reset = 1'b0;
        #2;
        check("rst_d4", 8'(dout4), 8'h00);
        check("rst_d8", dout8, 8'h00);
`ifdef UNIVERSAL_SHIFT_REG_SEROUT_EN
        check("rst_s4", 8'(sout4), 8'h00);
        check("rst_s8", 8'(sout8), 8'h00);
`endif
        #3 reset = 1'b1;
        #2 run = 1'b1;

        // Load then hold
        mode4 = 2'b11; din4 = 4'b1010;
        edge_step();
        check("load_1010", 8'(dout4), 8'h0A);
        mode4 = 2'b00; din4 = 4'b1111;
        edge_step();
        edge_step();
        edge_step();
        check("hold_3x", 8'(dout4), 8'h0A);
`ifdef UNIVERSAL_SHIFT_REG_SEROUT_EN
        check("hold_s", 8'(sout4), 8'h00);
`endif

        // Right shifts
        mode4 = 2'b01; din4 = 4'b0011;
        edge_step();
        check("shr1_d", 8'(dout4), 8'h05);
`ifdef UNIVERSAL_SHIFT_REG_SEROUT_EN
        check("shr1_s", 8'(sout4), 8'h00);
`endif
        din4 = 4'b1000;
        edge_step();
        check("shr2_d", 8'(dout4), 8'h0A);
`ifdef UNIVERSAL_SHIFT_REG_SEROUT_EN
        check("shr2_s", 8'(sout4), 8'h01);
`endif

        // Load 0101 (serial-out holds), then left shifts
        mode4 = 2'b11; din4 = 4'b0101;
        edge_step();
        check("load_0101", 8'(dout4), 8'h05);
`ifdef UNIVERSAL_SHIFT_REG_SEROUT_EN
        check("load_s_hold", 8'(sout4), 8'h01);
`endif
        mode4 = 2'b10; din4 = 4'b0111;
        edge_step();
        check("shl1_d", 8'(dout4), 8'h0B);
`ifdef UNIVERSAL_SHIFT_REG_SEROUT_EN
        check("shl1_s", 8'(sout4), 8'h00);
`endif
        din4 = 4'b0110;
        edge_step();
        check("shl2_d", 8'(dout4), 8'h06);
`ifdef UNIVERSAL_SHIFT_REG_SEROUT_EN
        check("shl2_s", 8'(sout4), 8'h01);
`endif

        // WIDTH 8: load A5, right shift with DATAIN[7]=1, then left shift
        mode8 = 2'b11; din8 = 8'hA5;
        edge_step();
        check("w8_load", dout8, 8'hA5);
        mode8 = 2'b01; din8 = 8'h80;
        edge_step();
        check("w8_shr", dout8, 8'hD2);
`ifdef UNIVERSAL_SHIFT_REG_SEROUT_EN
        check("w8_shr_s", 8'(sout8), 8'h01);
`endif
        mode8 = 2'b10; din8 = 8'hFE;
        edge_step();
        check("w8_shl", dout8, 8'hA4);
`ifdef UNIVERSAL_SHIFT_REG_SEROUT_EN
        check("w8_shl_s", 8'(sout8), 8'h01);
`endif
        mode8 = 2'b00; din8 = 8'hFF;
        edge_step();
        check("w8_hold", dout8, 8'hA4);

        // Mid-operation reset during left shifts from 1111
        mode4 = 2'b11; din4 = 4'b1111;
        edge_step();
        mode4 = 2'b10; din4 = 4'b0000;
        edge_step();
        check("mr_shl", 8'(dout4), 8'h0E);
        #2 reset = 1'b0;
        #1;
        check("mr_async_d4", 8'(dout4), 8'h00);
        check("mr_async_d8", dout8, 8'h00);
`ifdef UNIVERSAL_SHIFT_REG_SEROUT_EN
        check("mr_async_s4", 8'(sout4), 8'h00);
`endif
        din4 = 4'b1111;
        edge_step();
        check("mr_held", 8'(dout4), 8'h00);
        reset = 1'b1;
        mode4 = 2'b11; din4 = 4'b0111;
        edge_step();
        check("mr_reload", 8'(dout4), 8'h07);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
